// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Evaluates one conditional branch per request: compares rs1 against rs2
// according to funct3 and produces the taken flag, the next PC, the compare
// flags {N,V,Z} and an illegal-code flag. The unit has three states:
//   IDLE - waits for a request
//   CALC - computes the result from the captured operands
//   HOLD - presents the result until the consumer takes it
// There is one request in flight at a time. The result appears two edges
// after the request is offered, counting the accept edge as the first.
//
// Parameters
//   WIDTH      operand, PC and target width in bits
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request (IDLE and not in reset)
//   rs1, rs2   compare operands
//   funct3     branch condition code
//   pc         address of the branch instruction
//   imm        sign-extended branch offset
//   out_valid  result present (high exactly while in HOLD)
//   out_ready  consumer accepts the result
//   taken      branch condition true
//   target     next PC: pc+imm if taken, else pc+4 (wraps silently)
//   status     compare flags {NEGATIVE, OVERFLOW, ZERO}
//   error      funct3 was not a legal branch code
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic [2:0]       status,
  output logic             error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  logic [1:0]       r_state;

  // Captured request
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_imm;

  // Registered result
  logic             r_taken;
  logic [WIDTH-1:0] r_target;
  logic [2:0]       r_status;
  logic             r_error;

  // Compare datapath
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_n;
  logic             w_v;
  logic             w_z;
  logic             w_taken;
  logic             w_error;
  logic [WIDTH-1:0] w_target;

  // One extra bit on the subtraction yields the unsigned borrow for free:
  // the top bit is set exactly when rs1 < rs2 as unsigned numbers.
  assign {w_borrow, w_diff} = {1'b0, r_rs1} - {1'b0, r_rs2};

  assign w_n = w_diff[WIDTH-1];
  // Signed overflow of a subtraction: operands of different sign and the
  // result's sign disagrees with the minuend.
  assign w_v = (r_rs1[WIDTH-1] != r_rs2[WIDTH-1]) &&
               (w_diff[WIDTH-1] != r_rs1[WIDTH-1]);
  assign w_z = (w_diff == '0);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_taken = 1'b0;
    w_error = 1'b0;
    case (r_funct3)
      F_BEQ:   w_taken = w_z;
      F_BNE:   w_taken = !w_z;
      F_BLT:   w_taken = w_n ^ w_v;
      F_BGE:   w_taken = !(w_n ^ w_v);
      F_BLTU:  w_taken = w_borrow;
      F_BGEU:  w_taken = !w_borrow;
      default: w_error = 1'b1;  // 010 and 011 are not branch codes
    endcase
  end

  assign w_target = w_taken ? (r_pc + r_imm) : (r_pc + WIDTH'(4));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct3 <= '0;
      r_pc     <= '0;
      r_imm    <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
      r_status <= 3'b000;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_rs1    <= rs1;
            r_rs2    <= rs2;
            r_funct3 <= funct3;
            r_pc     <= pc;
            r_imm    <= imm;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_taken  <= w_taken;
          r_target <= w_target;
          r_status <= {w_n, w_v, w_z};
          r_error  <= w_error;
          r_state  <= HOLD;
        end
        HOLD: begin
          // Result registers are untouched here, so they stay stable for
          // as long as the consumer stalls.
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // rst_n is folded in so in_ready is low during reset without waiting
  // for the state register.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == HOLD);
  assign taken     = r_taken;
  assign target    = r_target;
  assign status    = r_status;
  assign error     = r_error;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//
// Directed-vector bench for branch_unit. The driver pushes the hand-computed
// result of each request into a queue when it offers the request; a separate
// monitor pops an entry whenever a new result appears on out_valid and
// compares it on every cycle the result is held.
// -----------------------------------------------------------------------------
module tb_branch_unit;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [2:0]  status;
    logic        error;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [WIDTH-1:0] target;
  logic [2:0]       status;
  logic             error;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  branch_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .pc        (pc),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .target    (target),
    .status    (status),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic t, input logic [31:0] tg,
                              input logic [2:0] st, input logic er);
    exp_t e;
    e.taken  = t;
    e.target = tg;
    e.status = st;
    e.error  = er;
    return e;
  endfunction

  // Offers one request, pushes its expected result, and checks the latency:
  // CALC after the accept edge, HOLD after the next one. Returns in HOLD,
  // 1 time unit after that edge. waits = edges spent waiting for in_ready.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] p,
                       input logic [31:0] im, input exp_t e, output int waits);
    in_valid = 1'b1;
    rs1      = a;
    rs2      = b;
    funct3   = f;
    pc       = p;
    imm      = im;
    waits    = 0;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #2;
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("calc_out_valid", 64'(out_valid), 64'd0);
      check("calc_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
  endtask

  // Monitor: a rising out_valid starts a new result (pop); every cycle the
  // result is held it must match, which also proves stability under stall.
  initial begin : monitor
    exp_t cur;
    logic seen;
    seen = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 64'(out_valid), 64'd0);
          end else begin
            cur  = sb.pop_front();
            seen = 1'b1;
          end
        end
        if (seen) begin
          check("result", 64'({taken, target, status, error}), 64'(cur));
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int waits;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rs1       = '0;
    rs2       = '0;
    funct3    = '0;
    pc        = '0;
    imm       = '0;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_outputs",   64'({taken, target, status, error}), 64'd0);
    #9 rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;

    // BEQ equal: Z=1
    issue(32'h5, 32'h5, 3'b000, 32'h100, 32'h20, mk(1'b1, 32'h120, 3'b001, 1'b0), waits);
    // BLT with signed overflow: 0x80000000 - 1 -> N=0, V=1
    issue(32'h8000_0000, 32'h1, 3'b100, 32'h200, 32'h40, mk(1'b1, 32'h240, 3'b010, 1'b0), waits);
    // BLTU vs BLT on 0xFFFFFFFF vs 1: unsigned not less, signed less
    issue(32'hFFFF_FFFF, 32'h1, 3'b110, 32'h300, 32'h80, mk(1'b0, 32'h304, 3'b100, 1'b0), waits);
    issue(32'hFFFF_FFFF, 32'h1, 3'b100, 32'h300, 32'h80, mk(1'b1, 32'h380, 3'b100, 1'b0), waits);
    // BNE with target wrap-around
    issue(32'h1, 32'h2, 3'b001, 32'hFFFF_FFFC, 32'h8, mk(1'b1, 32'h4, 3'b100, 1'b0), waits);
    // Illegal codes: flags still reported, never taken
    issue(32'h7, 32'h3, 3'b011, 32'h400, 32'h10, mk(1'b0, 32'h404, 3'b000, 1'b1), waits);
    issue(32'h9, 32'h9, 3'b010, 32'h480, 32'h10, mk(1'b0, 32'h484, 3'b001, 1'b1), waits);
    // Remaining codes and not-taken polarities
    issue(32'h3, 32'h5, 3'b101, 32'h500, 32'h10, mk(1'b0, 32'h504, 3'b100, 1'b0), waits);
    issue(32'h5, 32'h3, 3'b111, 32'h600, 32'hFFFF_FFF0, mk(1'b1, 32'h5F0, 3'b000, 1'b0), waits);
    issue(32'h1, 32'h2, 3'b000, 32'h680, 32'h10, mk(1'b0, 32'h684, 3'b100, 1'b0), waits);
    issue(32'h0, 32'h0, 3'b001, 32'h6C0, 32'h10, mk(1'b0, 32'h6C4, 3'b001, 1'b0), waits);
    issue(32'h1, 32'hFFFF_FFFF, 3'b110, 32'h6E0, 32'h20, mk(1'b1, 32'h700, 3'b000, 1'b0), waits);
    @(posedge clk); #1;

    // Backpressure: stall 5 edges in HOLD while a competing request is offered
    out_ready = 1'b0;
    issue(32'h10, 32'h10, 3'b101, 32'h700, 32'h100, mk(1'b1, 32'h800, 3'b001, 1'b0), waits);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rs1      = 32'hDEAD_0000 + 32'(i);
      rs2      = 32'h0;
      funct3   = 3'b000;
      pc       = 32'hA000;
      imm      = 32'h4;
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    // Release and present the next request at the same time
    out_ready = 1'b1;
    rs1       = 32'h10;
    rs2       = 32'h11;
    funct3    = 3'b001;
    pc        = 32'h900;
    imm       = 32'h8;
    sb.push_back(mk(1'b1, 32'h908, 3'b100, 1'b0));
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_ready", 64'(in_ready),  64'd0);
    check("bp_accept_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    check("bp_next_done", 64'(out_valid), 64'd0);

    // Reset during CALC: outputs clear at once, request is abandoned.
    // Outputs currently hold the previous (non-zero) result.
    @(posedge clk); #2;
    in_valid = 1'b1;
    rs1      = 32'h5;
    rs2      = 32'h5;
    funct3   = 3'b000;
    pc       = 32'hB00;
    imm      = 32'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_in_calc", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd0);
    check("abort_outputs",   64'({taken, target, status, error}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("abort_rel_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 64'(out_valid), 64'd0);
    end

    // First request after reset is accepted at the first edge
    issue(32'h0, 32'h0, 3'b000, 32'h0, 32'hC, mk(1'b1, 32'hC, 3'b001, 1'b0), waits);
    check("post_rst_waits", 64'(waits), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
